// File: rtl/lc3_pkg.sv
// Shared LC-3 decode types: opcode map, execute-control field layout and writeback selects.
package lc3_pkg;

  typedef enum logic [3:0] {
    OpBr  = 4'b0000,
    OpAdd = 4'b0001,
    OpLd  = 4'b0010,
    OpSt  = 4'b0011,
    OpAnd = 4'b0101,
    OpLdr = 4'b0110,
    OpStr = 4'b0111,
    OpNot = 4'b1001,
    OpLdi = 4'b1010,
    OpSti = 4'b1011,
    OpJmp = 4'b1100,
    OpLea = 4'b1110
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluAnd = 2'b01;
  localparam logic [1:0] AluNot = 2'b10;

  localparam logic [1:0] WSelAlu = 2'b00;
  localparam logic [1:0] WSelMem = 2'b01;
  localparam logic [1:0] WSelPc  = 2'b10;

endpackage

// File: rtl/lc3_decode_lut.sv
// Combinational opcode-to-control table; anything outside the map decodes to all-zero controls.
module lc3_decode_lut
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_sel,
  output e_control_t e_control,
  output logic [1:0] w_control,
  output logic       mem_control,
  output logic       illegal
);

  always_comb begin
    e_control   = '0;
    w_control   = WSelAlu;
    mem_control = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OpAdd: begin
        e_control.alu_control = AluAdd;
        e_control.op2select   = ~imm_sel;
      end
      OpAnd: begin
        e_control.alu_control = AluAnd;
        e_control.op2select   = ~imm_sel;
      end
      OpNot: e_control.alu_control = AluNot;
      OpBr, OpSt: begin
        e_control.pcselect1 = 2'b01;
        e_control.pcselect2 = 1'b1;
      end
      OpLd: begin
        e_control.pcselect1 = 2'b01;
        e_control.pcselect2 = 1'b1;
        w_control           = WSelMem;
      end
      OpLdi: begin
        e_control.pcselect1 = 2'b01;
        e_control.pcselect2 = 1'b1;
        w_control           = WSelMem;
        mem_control         = 1'b1;
      end
      OpSti: begin
        e_control.pcselect1 = 2'b01;
        e_control.pcselect2 = 1'b1;
        mem_control         = 1'b1;
      end
      OpLea: begin
        e_control.pcselect1 = 2'b01;
        e_control.pcselect2 = 1'b1;
        w_control           = WSelPc;
      end
      OpLdr: begin
        e_control.pcselect1 = 2'b10;
        w_control           = WSelMem;
      end
      OpStr: e_control.pcselect1 = 2'b10;
      OpJmp: e_control.pcselect1 = 2'b11;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers instruction, next-PC and decoded controls in one cycle.
// Optional LC3_DECODE_ILLEGAL_DET_EN adds a registered 'illegal' flag for unsupported opcodes.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] instr_dout,
  input  logic [2:0]        psr,
  input  logic              enable_decode,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] npc_out,
  output logic [5:0]        E_control,
  output logic [1:0]        W_control,
  output logic              Mem_control,
  output logic              decode_valid
`ifdef LC3_DECODE_ILLEGAL_DET_EN
  ,
  output logic              illegal
`endif
);

  e_control_t lut_e;
  logic [1:0] lut_w;
  logic       lut_mem;
  logic       lut_illegal;

  e_control_t e_q;
  logic [1:0] w_q;
  logic       mem_q;

  // Condition codes are consumed later in the pipe, never here.
  logic unused_psr;
  assign unused_psr = ^psr;

  lc3_decode_lut u_lut (
    .opcode      (instr_dout[DATA_W-1 -: 4]),
    .imm_sel     (instr_dout[5]),
    .e_control   (lut_e),
    .w_control   (lut_w),
    .mem_control (lut_mem),
    .illegal     (lut_illegal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      IR           <= '0;
      npc_out      <= '0;
      e_q          <= '0;
      w_q          <= '0;
      mem_q        <= 1'b0;
      decode_valid <= 1'b0;
    end else begin
      decode_valid <= enable_decode;
      if (enable_decode) begin
        IR      <= instr_dout;
        npc_out <= npc_in;
        e_q     <= lut_e;
        w_q     <= lut_w;
        mem_q   <= lut_mem;
      end
    end
  end

  assign E_control   = e_q;
  assign W_control   = w_q;
  assign Mem_control = mem_q;

`ifdef LC3_DECODE_ILLEGAL_DET_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else begin
      illegal <= enable_decode & lut_illegal;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = lut_illegal;
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// Directed table-driven bench for lc3_decode, plus hold and asynchronous-reset sequences.
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] npc_in;
  logic [15:0] instr_dout;
  logic [2:0]  psr;
  logic        enable_decode;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        Mem_control;
  logic        decode_valid;
`ifdef LC3_DECODE_ILLEGAL_DET_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lc3_decode #(.DATA_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .npc_in        (npc_in),
    .instr_dout    (instr_dout),
    .psr           (psr),
    .enable_decode (enable_decode),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_control     (E_control),
    .W_control     (W_control),
    .Mem_control   (Mem_control),
    .decode_valid  (decode_valid)
`ifdef LC3_DECODE_ILLEGAL_DET_EN
    ,
    .illegal       (illegal)
`endif
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
    logic [2:0]  psr;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        mem;
    logic        ill;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                           input logic [5:0] e, input logic [1:0] w, input logic mem,
                           input logic vld, input logic ill);
    check({tag, ".IR"}, 32'(IR), 32'(ir));
    check({tag, ".npc_out"}, 32'(npc_out), 32'(npc));
    check({tag, ".E_control"}, 32'(E_control), 32'(e));
    check({tag, ".W_control"}, 32'(W_control), 32'(w));
    check({tag, ".Mem_control"}, 32'(Mem_control), 32'(mem));
    check({tag, ".decode_valid"}, 32'(decode_valid), 32'(vld));
`ifdef LC3_DECODE_ILLEGAL_DET_EN
    check({tag, ".illegal"}, 32'(illegal), 32'(ill));
`else
    if (ill === 1'bx) $display("unexpected X flag in %s", tag);
`endif
  endtask

  initial begin
    //            instr     npc       psr   E_control  W      Mem   ill
    vecs[0]  = '{16'h1283, 16'h3001, 3'b001, 6'b000001, 2'b00, 1'b0, 1'b0}; // ADD reg
    vecs[1]  = '{16'h12A3, 16'h3002, 3'b010, 6'b000000, 2'b00, 1'b0, 1'b0}; // ADD imm
    vecs[2]  = '{16'h5062, 16'h3003, 3'b100, 6'b010000, 2'b00, 1'b0, 1'b0}; // AND imm
    vecs[3]  = '{16'h5042, 16'h3004, 3'b111, 6'b010001, 2'b00, 1'b0, 1'b0}; // AND reg
    vecs[4]  = '{16'h967F, 16'h3005, 3'b000, 6'b100000, 2'b00, 1'b0, 1'b0}; // NOT
    vecs[5]  = '{16'h0E05, 16'h3006, 3'b001, 6'b000110, 2'b00, 1'b0, 1'b0}; // BR
    vecs[6]  = '{16'hC1C0, 16'h3007, 3'b010, 6'b001100, 2'b00, 1'b0, 1'b0}; // JMP
    vecs[7]  = '{16'h2405, 16'h3008, 3'b100, 6'b000110, 2'b01, 1'b0, 1'b0}; // LD
    vecs[8]  = '{16'h6285, 16'h3009, 3'b001, 6'b001000, 2'b01, 1'b0, 1'b0}; // LDR
    vecs[9]  = '{16'hA405, 16'h300A, 3'b010, 6'b000110, 2'b01, 1'b1, 1'b0}; // LDI
    vecs[10] = '{16'hE405, 16'h300B, 3'b100, 6'b000110, 2'b10, 1'b0, 1'b0}; // LEA
    vecs[11] = '{16'h3405, 16'h300C, 3'b001, 6'b000110, 2'b00, 1'b0, 1'b0}; // ST
    vecs[12] = '{16'h7285, 16'h300D, 3'b010, 6'b001000, 2'b00, 1'b0, 1'b0}; // STR
    vecs[13] = '{16'hB405, 16'h300E, 3'b100, 6'b000110, 2'b00, 1'b1, 1'b0}; // STI
    vecs[14] = '{16'hF025, 16'h300F, 3'b001, 6'b000000, 2'b00, 1'b0, 1'b1}; // TRAP
    vecs[15] = '{16'h4ABC, 16'h3010, 3'b010, 6'b000000, 2'b00, 1'b0, 1'b1}; // 0100
    vecs[16] = '{16'h8000, 16'h3011, 3'b100, 6'b000000, 2'b00, 1'b0, 1'b1}; // 1000
    vecs[17] = '{16'hD1E3, 16'h3012, 3'b001, 6'b000000, 2'b00, 1'b0, 1'b1}; // 1101

    reset = 1'b0;
    enable_decode = 1'b1;
    instr_dout = 16'h1283;
    npc_in = 16'h3001;
    psr = 3'b000;
    @(posedge clock); #1;
    check_all("reset", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Back-to-back captures: decode_valid must stay high throughout.
    foreach (vecs[i]) begin
      instr_dout = vecs[i].instr;
      npc_in = vecs[i].npc;
      psr = vecs[i].psr;
      enable_decode = 1'b1;
      @(posedge clock); #1;
      check_all($sformatf("vec%0d", i), vecs[i].instr, vecs[i].npc, vecs[i].e, vecs[i].w,
                vecs[i].mem, 1'b1, vecs[i].ill);
    end

    // Capture AND imm, then freeze for three cycles while inputs churn.
    instr_dout = 16'h5062;
    npc_in = 16'h4000;
    @(posedge clock); #1;
    check_all("and_cap", 16'h5062, 16'h4000, 6'b010000, 2'b00, 1'b0, 1'b1, 1'b0);
    enable_decode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      instr_dout = 16'hA405 + 16'(c);
      npc_in = 16'h5555 + 16'(c);
      psr = 3'(c + 3);
      @(posedge clock); #1;
      check_all($sformatf("hold%0d", c), 16'h5062, 16'h4000, 6'b010000, 2'b00, 1'b0, 1'b0,
                1'b0);
    end

    // Load nonzero state (LDI), then assert reset between edges.
    enable_decode = 1'b1;
    instr_dout = 16'hA405;
    npc_in = 16'h6001;
    @(posedge clock); #1;
    check_all("pre_rst", 16'hA405, 16'h6001, 6'b000110, 2'b01, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    // Enable held high across an edge while reset is low: nothing captured.
    instr_dout = 16'h6285;
    npc_in = 16'h7001;
    @(posedge clock); #1;
    check_all("rst_edge", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_all("rst_rel", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    check_all("first_cap", 16'h6285, 16'h7001, 6'b001000, 2'b01, 1'b0, 1'b1, 1'b0);

    // Unsupported opcode after reset, then one idle cycle clears the flag.
    instr_dout = 16'hF025;
    npc_in = 16'h7002;
    @(posedge clock); #1;
    check_all("trap", 16'hF025, 16'h7002, 6'b0, 2'b0, 1'b0, 1'b1, 1'b1);
    enable_decode = 1'b0;
    @(posedge clock); #1;
    check_all("trap_idle", 16'hF025, 16'h7002, 6'b0, 2'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_decode.md
LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 SHALL have parameter: DATA_W, 16, instruction/PC width (only 16 supported).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port: npc_in  input  16  next-PC accompanying the instruction.
REQ-005 SHALL have port: instr_dout  input  16  instruction word from instruction memory.
REQ-006 SHALL have port: psr  input  3  NZP status; accepted, no effect on any output.
REQ-007 SHALL have port: enable_decode  input  1  qualifies the inputs for capture this edge.
REQ-008 SHALL have port: IR  output  16  registered instruction.
REQ-009 SHALL have port: npc_out  output  16  registered npc_in.
REQ-010 SHALL have port: E_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-011 SHALL have port: W_control  output  2  writeback select: 00 ALU, 01 memory, 10 PC-relative.
REQ-012 SHALL have port: Mem_control  output  1  1 = indirect access (LDI/STI).
REQ-013 SHALL have port: decode_valid  output  1  outputs updated by the previous edge.

Function
REQ-014 On a rising edge with enable_decode=1, SHALL register IR<=instr_dout and npc_out<=npc_in, plus decoded controls; latency exactly 1 cycle.
REQ-015 Decoded controls SHALL be registered from the same edge as IR; no combinational input-to-output path.
REQ-016 With enable_decode=0, SHALL hold IR, npc_out, E_control, W_control and Mem_control, and drive decode_valid<=0.
REQ-017 decode_valid SHALL be 1 for each cycle following an enabled edge; back-to-back enables give continuous decode_valid=1.
REQ-018 Opcode map (IR[15:12]): ADD 0001, AND 0101, NOT 1001, BR 0000, JMP 1100, LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011.
REQ-019 alu_control SHALL be 00 ADD, 01 AND, 10 NOT, and 00 for all other ops.
REQ-020 op2select SHALL be 1 for ADD/AND with instr[5]=0 (register operand), and 0 otherwise (imm5 or non-ALU).
REQ-021 {pcselect1,pcselect2} SHALL be: BR/LD/LDI/ST/STI/LEA 01,1; LDR/STR 10,0; JMP 11,0; ALU ops 00,0.
REQ-022 W_control SHALL be: LD/LDR/LDI 01; LEA 10; all others 00.
REQ-023 Mem_control SHALL be 1 only for LDI and STI.
REQ-024 Unsupported opcodes (0100, 1000, 1101, 1111) SHALL decode to E_control=0, W_control=0 and Mem_control=0; IR and npc_out are still captured.
REQ-025 psr changes SHALL NOT alter any output.

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) clear IR, npc_out, E_control, W_control, Mem_control and decode_valid to 0.
REQ-027 Reset SHALL take priority over a coincident enable_decode=1; the first capture occurs on the first rising edge after reset deasserts.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight capture; no state survives.

Configuration
REQ-029 With macro LC3_DECODE_ILLEGAL_DET_EN defined, SHALL add output illegal (1 bit), registered with decode_valid, =1 when an enabled edge captured an unsupported opcode; reset value 0; held-low when enable_decode=0.
REQ-030 Without LC3_DECODE_ILLEGAL_DET_EN, the illegal port SHALL be absent and REQ-024 behaviour SHALL be unchanged.

Structure
REQ-031 Package lc3_pkg SHALL hold the opcode enum, the E_control field typedef (struct packed), and the W_control encoding constants.
REQ-032 The combinational opcode-to-control table SHALL be sub-module lc3_decode_lut; lc3_decode holds all registers.

Verification
REQ-033 Reset, then enable with instr 16'h1283 (ADD R1,R2,R3), npc 16'h3001 -> next cycle: IR=1283, npc_out=3001, E_control=6'b000001, W_control=00, decode_valid=1.
REQ-034 Enable with instr 16'h6285 (LDR) -> E_control=6'b001000, W_control=01, Mem_control=0; then enable with 16'hA405 (LDI) -> Mem_control=1, W_control=01, E_control=6'b000110.
REQ-035 Capture 16'h5062 (AND imm), then hold enable_decode=0 for 3 cycles while changing instr/npc/psr -> outputs frozen, decode_valid=0 for all 3 cycles.
REQ-036 Drive reset=0 between clock edges while outputs are nonzero -> all outputs 0 before the next edge; enable=1 on the edge where reset releases -> no capture.
REQ-037 Enable with 16'hF025 (TRAP) -> E/W/Mem controls 0, IR=F025; with LC3_DECODE_ILLEGAL_DET_EN, illegal=1 for one cycle; without it, the illegal port is absent.
